// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - received-byte output register handshake and status pulses
`timescale 1ns/1ps
interface uart_rx_if;
  logic [7:0] data_out;
  logic       data_valid;
  logic       data_ready;
  logic       frame_err;
  logic       overrun;

  modport master (output data_out, data_valid, frame_err, overrun, input data_ready);
  modport slave  (input data_out, data_valid, frame_err, overrun, output data_ready);
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver: 8N1 with start-glitch rejection, framing-error and overrun flags
`timescale 1ns/1ps
module uart_rx #(
  parameter int CLK_PER_BIT = 434
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     rx,
  output logic     busy,
  uart_rx_if.master out_if
);

  localparam logic [15:0] H_CNT  = 16'((CLK_PER_BIT - 1) / 2);
  localparam logic [15:0] CPB_M1 = 16'(CLK_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

  state_t      state_q, state_d;
  logic [15:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        rx_meta_q, rx_meta_d;
  logic        rx_s_q, rx_s_d;
  logic [7:0]  data_out_q, data_out_d;
  logic        data_valid_q, data_valid_d;
  logic        frame_err_q, frame_err_d;
  logic        overrun_q, overrun_d;
  logic        deliver;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      clk_cnt_q    <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      clk_cnt_q    <= clk_cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      rx_meta_q    <= rx_meta_d;
      rx_s_q       <= rx_s_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    clk_cnt_d    = clk_cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    rx_meta_d    = rx;
    rx_s_d       = rx_meta_q;
    data_out_d   = data_out_q;
    data_valid_d = data_valid_q;
    frame_err_d  = 1'b0;
    overrun_d    = 1'b0;
    deliver      = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d   = START;
          clk_cnt_d = '0;
        end
      end
      START: begin
        // Re-check the line at mid start bit so short low glitches are ignored.
        if (clk_cnt_q == H_CNT) begin
          clk_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = rx_s_q ? IDLE : DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end
      end
      DATA: begin
        if (clk_cnt_q == CPB_M1) begin
          shift_d[bit_idx_q] = rx_s_q;
          clk_cnt_d          = '0;
          if (bit_idx_q == 3'd7) state_d = STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end
      end
      STOP: begin
        // Leaving at mid stop bit leaves half a bit to catch a back-to-back start edge.
        if (clk_cnt_q == CPB_M1) begin
          clk_cnt_d = '0;
          if (rx_s_q) begin
            deliver = 1'b1;
            state_d = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = BRK;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end
      end
      BRK: begin
        if (rx_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (deliver) begin
      if (!data_valid_q || out_if.data_ready) begin
        data_out_d   = shift_q;
        data_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (data_valid_q && out_if.data_ready) begin
      data_valid_d = 1'b0;
    end
  end

  assign busy              = (state_q != IDLE);
  assign out_if.data_out   = data_out_q;
  assign out_if.data_valid = data_valid_q;
  assign out_if.frame_err  = frame_err_q;
  assign out_if.overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed, table-driven bench for uart_rx at CLK_PER_BIT=16
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int CPB = 16;
  localparam int H   = (CPB - 1) / 2;
  localparam int LAT = 1 + 3 + H + 9 * CPB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;
  logic busy;

  uart_rx_if u_if ();

  uart_rx #(.CLK_PER_BIT(CPB)) dut (
    .clk    (clk),
    .rst    (rst),
    .rx     (rx),
    .busy   (busy),
    .out_if (u_if.master)
  );

  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  int dv_cycles   = 0;
  int fe_cnt      = 0;
  int ov_cnt      = 0;
  int both_cnt    = 0;
  int busy_cycles = 0;
  logic [7:0] rxq[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (u_if.data_valid) dv_cycles++;
      if (u_if.data_valid && u_if.data_ready) rxq.push_back(u_if.data_out);
      if (u_if.frame_err) fe_cnt++;
      if (u_if.overrun) ov_cnt++;
      if (u_if.frame_err && u_if.overrun) both_cnt++;
      if (busy) busy_cycles++;
    end
  end

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_dv;
    int         exp_fe;
    logic [7:0] exp_byte;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  // Called on a negedge; leaves rx idle high on a negedge.
  task automatic send_frame(input logic [7:0] d, input logic stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  int dv0, fe0, ov0, bz0, q0, n;

  initial begin
    vecs[0] = '{data: 8'hA5, stop: 1'b1, exp_dv: 1, exp_fe: 0, exp_byte: 8'hA5};
    vecs[1] = '{data: 8'h3C, stop: 1'b0, exp_dv: 0, exp_fe: 1, exp_byte: 8'h00};
    vecs[2] = '{data: 8'h01, stop: 1'b1, exp_dv: 1, exp_fe: 0, exp_byte: 8'h01};
    vecs[3] = '{data: 8'h80, stop: 1'b1, exp_dv: 1, exp_fe: 0, exp_byte: 8'h80};
    vecs[4] = '{data: 8'hFE, stop: 1'b0, exp_dv: 0, exp_fe: 1, exp_byte: 8'h00};

    u_if.data_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_data_valid", int'(u_if.data_valid), 0);
    check("reset_data_out", int'(u_if.data_out), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_frame_err", int'(u_if.frame_err), 0);
    check("reset_overrun", int'(u_if.overrun), 0);
    rst = 1'b0;
    u_if.data_ready = 1'b1;
    repeat (5) @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      dv0 = dv_cycles; fe0 = fe_cnt; ov0 = ov_cnt; q0 = rxq.size();
      send_frame(vecs[v].data, vecs[v].stop);
      repeat (40) @(negedge clk);
      check($sformatf("vec%0d_dv_cycles", v), dv_cycles - dv0, vecs[v].exp_dv);
      check($sformatf("vec%0d_frame_err", v), fe_cnt - fe0, vecs[v].exp_fe);
      check($sformatf("vec%0d_overrun", v), ov_cnt - ov0, 0);
      if (vecs[v].exp_dv != 0 && rxq.size() > q0)
        check($sformatf("vec%0d_byte", v), int'(rxq[rxq.size()-1]), int'(vecs[v].exp_byte));
      check($sformatf("vec%0d_idle", v), int'(busy), 0);
    end

    fork
      send_frame(8'h96, 1'b1);
      begin
        n = 0;
        while (!u_if.data_valid && n < 400) begin
          @(posedge clk);
          n++;
          @(negedge clk);
        end
      end
    join
    check("latency_window", int'(n >= LAT - 1 && n <= LAT + 1), 1);
    repeat (20) @(negedge clk);

    dv0 = dv_cycles; fe0 = fe_cnt; ov0 = ov_cnt; bz0 = busy_cycles;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    check("glitch_busy_seen", int'(busy_cycles > bz0), 1);
    check("glitch_idle", int'(busy), 0);
    check("glitch_no_dv", dv_cycles - dv0, 0);
    check("glitch_no_flags", (fe_cnt - fe0) + (ov_cnt - ov0), 0);

    dv0 = dv_cycles; fe0 = fe_cnt;
    send_frame(8'h3C, 1'b0);
    rx = 1'b0;
    repeat (40 * CPB) @(negedge clk);
    check("brk_single_frame_err", fe_cnt - fe0, 1);
    check("brk_still_busy", int'(busy), 1);
    rx = 1'b1;
    repeat (10) @(negedge clk);
    check("brk_exit_idle", int'(busy), 0);
    check("brk_no_dv", dv_cycles - dv0, 0);

    u_if.data_ready = 1'b0;
    ov0 = ov_cnt; fe0 = fe_cnt;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    repeat (20) @(negedge clk);
    check("ovr_data_out_kept", int'(u_if.data_out), 8'h11);
    check("ovr_valid_held", int'(u_if.data_valid), 1);
    check("ovr_single_pulse", ov_cnt - ov0, 1);
    check("ovr_no_frame_err", fe_cnt - fe0, 0);
    q0 = rxq.size();
    u_if.data_ready = 1'b1;
    @(negedge clk);
    check("ovr_valid_drops", int'(u_if.data_valid), 0);
    check("ovr_accepted_count", rxq.size() - q0, 1);
    if (rxq.size() > q0) check("ovr_accepted_byte", int'(rxq[q0]), 8'h11);
    repeat (5) @(negedge clk);

    q0 = rxq.size(); fe0 = fe_cnt; ov0 = ov_cnt;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h55, 1'b1);
    send_frame(8'h80, 1'b1);
    repeat (20) @(negedge clk);
    check("loop_count", rxq.size() - q0, 4);
    if (rxq.size() >= q0 + 4) begin
      check("loop_b0", int'(rxq[q0]), 8'h00);
      check("loop_b1", int'(rxq[q0+1]), 8'hFF);
      check("loop_b2", int'(rxq[q0+2]), 8'h55);
      check("loop_b3", int'(rxq[q0+3]), 8'h80);
    end
    check("loop_no_flags", (fe_cnt - fe0) + (ov_cnt - ov0), 0);

    u_if.data_ready = 1'b0;
    send_frame(8'h77, 1'b1);
    repeat (20) @(negedge clk);
    check("rst_pending_valid", int'(u_if.data_valid), 1);
    fork
      send_frame(8'h5A, 1'b1);
      begin
        repeat (60) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_valid", int'(u_if.data_valid), 0);
        check("rst_mid_data_out", int'(u_if.data_out), 0);
        check("rst_mid_busy", int'(busy), 0);
        check("rst_mid_flags", int'(u_if.frame_err) + int'(u_if.overrun), 0);
      end
    join
    repeat (3) @(negedge clk);
    rst = 1'b0;
    u_if.data_ready = 1'b1;
    repeat (5) @(negedge clk);
    q0 = rxq.size();
    send_frame(8'hC3, 1'b1);
    repeat (20) @(negedge clk);
    check("post_rst_count", rxq.size() - q0, 1);
    if (rxq.size() > q0) check("post_rst_byte", int'(rxq[q0]), 8'hC3);

    check("never_both_flags", both_cnt, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
